// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader and the RV32I pipeline.
// Holds the loader state encoding, frame field widths and the default memory size.
package imem_loader_pkg;

  localparam int CNT_W          = 16;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader uses the slave view; the stream source / memory side uses the master view.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: a 2-bit lane counter plus an assembly register.
// word_valid fires combinationally on the 4th byte; that byte bypasses the register.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               lane_q, lane_d;
  logic [WORD_W-BYTE_W-1:0] asm_q, asm_d;

  // Bytes enter at the top and shift down, so byte 0 ends up in bits 7:0.
  assign word       = {byte_data, asm_q};
  assign word_valid = byte_valid && (lane_q == 2'd3);

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (byte_valid) begin
      lane_d = lane_q + 2'd1;
      asm_d  = {byte_data, asm_q[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted, XOR-checksummed byte frame into instruction memory
// and holds the pipeline in reset until the whole frame has been verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
)(
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         load_done,
  output logic         load_err
);

  localparam logic [CNT_W:0] CAPACITY = (CNT_W+1)'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [BYTE_W-1:0] cnt_lo_q, cnt_lo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              pack_valid;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  count_full;

  assign xfer       = bus.in_valid && in_ready_q;
  assign pack_valid = xfer && (state_q == S_DATA);
  assign count_full = {bus.in_data, cnt_lo_q};

  imem_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (pack_valid),
    .byte_data  (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_CNT_LO: if (xfer) begin
        cnt_lo_d = bus.in_data;
        state_d  = S_CNT_HI;
      end
      S_CNT_HI: if (xfer) begin
        n_d = count_full[ADDR_W:0];
        if ({1'b0, count_full} > CAPACITY) state_d = S_ERR;
        else if (count_full == '0)         state_d = S_CSUM;
        else                               state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        csum_d = csum_q ^ bus.in_data;
        if (word_valid) begin
          we_d       = 1'b1;
          addr_d     = word_cnt_q[ADDR_W-1:0];
          wdata_d    = word;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_d == n_q) state_d = S_CSUM;
        end
      end
      S_CSUM: if (xfer) begin
        state_d = (bus.in_data == csum_q) ? S_RUN : S_ERR;
      end
      default: ;
    endcase

    // Status flags are derived from the next state so they switch together with it.
    in_ready_d = state_d inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM};
    core_rst_d = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples values from before this edge.
    if (rst) begin
      state_q    <= S_CNT_LO;
      cnt_lo_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst       = core_rst_q;
  assign load_done      = done_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-word memory: nominal, bad checksum,
// oversize/empty counts, gapped stream, capacity boundary and mid-frame reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, load_done, load_err;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    int waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset(input string tag);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(posedge clk); #1;
    check({tag, "_in_ready"},   {31'd0, bus.in_ready},  32'd0);
    check({tag, "_imem_we"},    {31'd0, bus.imem_we},   32'd0);
    check({tag, "_imem_addr"},  {28'd0, bus.imem_addr}, 32'd0);
    check({tag, "_imem_wdata"}, bus.imem_wdata,         32'd0);
    check({tag, "_core_rst"},   {31'd0, core_rst},      32'd1);
    check({tag, "_load_done"},  {31'd0, load_done},     32'd0);
    check({tag, "_load_err"},   {31'd0, load_err},      32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_rise"}, {31'd0, bus.in_ready}, 32'd1);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_write(input string tag, input int idx,
                             input logic [AW-1:0] exp_addr, input logic [31:0] exp_data);
    if (idx < wr_addr.size()) begin
      check({tag, "_addr"}, {28'd0, wr_addr[idx]}, {28'd0, exp_addr});
      check({tag, "_data"}, wr_data[idx], exp_data);
    end else begin
      check({tag, "_missing"}, wr_addr.size(), idx + 1);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_core_rst,
                              input logic exp_done, input logic exp_err, input logic exp_ready);
    check({tag, "_core_rst"},  {31'd0, core_rst},     {31'd0, exp_core_rst});
    check({tag, "_load_done"}, {31'd0, load_done},    {31'd0, exp_done});
    check({tag, "_load_err"},  {31'd0, load_err},     {31'd0, exp_err});
    check({tag, "_in_ready"},  {31'd0, bus.in_ready}, {31'd0, exp_ready});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Nominal two-word load at one byte per cycle.
    do_reset("rst0");
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    check("nom_no_early_we", {31'd0, bus.imem_we}, 32'd0);
    send_byte(8'h00);
    check("nom_w0_we",   {31'd0, bus.imem_we},   32'd1);
    check("nom_w0_addr", {28'd0, bus.imem_addr}, 32'd0);
    check("nom_w0_data", bus.imem_wdata,         32'h0000_0013);
    send_word(32'h0050_0093);
    check("nom_w1_we",   {31'd0, bus.imem_we},   32'd1);
    check("nom_w1_addr", {28'd0, bus.imem_addr}, 32'd1);
    check("nom_w1_data", bus.imem_wdata,         32'h0050_0093);
    check_status("nom_pre_csum", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'hD0);
    check("nom_we_low",     {31'd0, bus.imem_we}, 32'd0);
    check("nom_wdata_hold", bus.imem_wdata,       32'h0050_0093);
    check_status("nom_done", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("nom_writes", wr_addr.size(), 32'd2);

    // Same frame with a wrong checksum, then stray traffic that must be ignored.
    do_reset("rst1");
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h0000_0013);
    send_word(32'h0050_0093);
    send_byte(8'hD1);
    check_status("bad_err", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bad_writes", wr_addr.size(), 32'd2);
    check_write("bad_w0", 0, 4'd0, 32'h0000_0013);
    check_write("bad_w1", 1, 4'd1, 32'h0050_0093);
    check("bad_no_we", {31'd0, bus.imem_we}, 32'd0);
    check_status("bad_stuck", 1'b1, 1'b0, 1'b1, 1'b0);

    // Oversize count: 17 words into a 16-word memory.
    do_reset("rst2");
    send_byte(8'h11); send_byte(8'h00);
    check_status("over_err", 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("over_writes", wr_addr.size(), 32'd0);

    // Empty frame.
    do_reset("rst3");
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check_status("empty_done", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("empty_writes", wr_addr.size(), 32'd0);

    // Gapped stream: idle cycle after every byte. CSUM = EF^BE^AD^DE = 22.
    do_reset("rst4");
    begin
      logic [7:0] gap_bytes [7];
      gap_bytes = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      for (int i = 0; i < 7; i++) begin
        send_byte(gap_bytes[i]);
        if (i < 6) begin
          @(posedge clk); #1;
        end
      end
    end
    check_status("gap_done", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("gap_writes", wr_addr.size(), 32'd1);
    check_write("gap_w0", 0, 4'd0, 32'hDEAD_BEEF);

    // Capacity boundary: 16 words; XOR of payload bytes cancels to 00.
    do_reset("rst5");
    send_byte(8'h10); send_byte(8'h00);
    for (int i = 0; i < 16; i++) send_word(32'h1000_0000 | i);
    send_byte(8'h00);
    check_status("cap_done", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("cap_writes", wr_addr.size(), 32'd16);
    for (int i = 0; i < 16; i++) check_write($sformatf("cap_w%0d", i), i, AW'(i), 32'h1000_0000 | i);

    // Reset after 6 payload bytes, then a fresh one-word frame. CSUM = 0D^F0^FE^CA = C9.
    do_reset("rst6");
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("mid_w0_data", bus.imem_wdata, 32'h4433_2211);
    send_byte(8'h55); send_byte(8'h66);
    do_reset("mid_rst");
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'hCAFE_F00D);
    check("mid_new_we",   {31'd0, bus.imem_we},   32'd1);
    check("mid_new_addr", {28'd0, bus.imem_addr}, 32'd0);
    check("mid_new_data", bus.imem_wdata,         32'hCAFE_F00D);
    send_byte(8'hC9);
    check_status("mid_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset from the run state re-arms the loader and re-asserts core reset.
    do_reset("rearm");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
